video_write_scheduler: RTL and testbench
========================================

VIDEO_WRITE_SCHEDULER -- requirements
Module: video_write_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the CPU pixel-write queue depth; power of two, at least 2.
REQ-002 SHALL have port Clock, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iCpuWrite, input, 1 bit: one-cycle strobe requesting a single-pixel write.
REQ-005 SHALL have ports iCpuCol, input, 8 bits and iCpuRow, input, 8 bits: target pixel of the CPU write.
REQ-006 SHALL have port iCpuColor, input, 3 bits: RGB value of the CPU write.
REQ-007 SHALL have port iFillStart, input, 1 bit: one-cycle strobe that starts a rectangle fill.
REQ-008 SHALL have ports iFillCol0, iFillRow0, iFillWidth and iFillHeight, input, 8 bits each: fill origin and size.
REQ-009 SHALL have port iFillColor, input, 3 bits: fill RGB value.
REQ-010 SHALL have port oFillBusy, output, 1 bit: high while the fill FSM is in FILL or DONE.
REQ-011 SHALL have port oFillDone, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port oCpuOverflow, output, 1 bit: sticky flag, set when a CPU write is dropped.
REQ-013 SHALL have port oWriteEnable, output, 1 bit: video RAM write enable.
REQ-014 SHALL have port oWriteAddress, output, 16 bits: {column[15:8], row[7:0]}.
REQ-015 SHALL have port oDataOut, output, 3 bits: pixel RGB.

Function
REQ-016 SHALL push {col,row,color} into the CPU FIFO at the edge on which iCpuWrite=1.
REQ-017 SHALL drop a push when the FIFO is full and no pop occurs in the same cycle, set oCpuOverflow, and leave stored entries unchanged.
REQ-018 SHALL accept a push and a pop in the same cycle when full, with occupancy unchanged.
REQ-019 SHALL implement fill FSM states IDLE, FILL and DONE.
REQ-020 IDLE: on iFillStart, latch all fill inputs and zero offsets x and y; go to DONE if width=0 or height=0, otherwise go to FILL.
REQ-021 FILL: each granted fill cycle issues pixel (col0+x mod 256, row0+y mod 256) in row-major order; x increments, and at x=width-1 x wraps to 0 and y increments.
REQ-022 FILL: after the grant of pixel (width-1, height-1), go to DONE; ungranted cycles hold x and y.
REQ-023 DONE: assert oFillDone for exactly one cycle, then return to IDLE.
REQ-024 SHALL ignore iFillStart outside IDLE.
REQ-025 SHALL grant at most one requester per cycle; requesters are CPU (FIFO non-empty) and fill (state FILL).
REQ-026 SHALL grant the sole requester when only one is requesting.
REQ-027 SHALL, when both request, grant the one not granted in the previous contested cycle; uncontested cycles leave this history unchanged.
REQ-028 SHALL register oWriteEnable, oWriteAddress and oDataOut from the grant.
REQ-029 SHALL make the output write visible 2 cycles after the accepted strobe when uncontested: strobe in cycle N, write in cycle N+2.
REQ-030 SHALL drive oWriteEnable=0 with address and data held in cycles with no grant.
REQ-031 SHALL complete an uncontested fill in exactly width*height consecutive write cycles.

Reset
REQ-032 SHALL, while Reset=0, immediately force oWriteEnable, oWriteAddress, oDataOut, oFillBusy, oFillDone and oCpuOverflow to 0.
REQ-033 SHALL, while Reset=0, empty the FIFO, set the FSM to IDLE, and set the contest history to "fill last", so the CPU wins the first contest.
REQ-034 SHALL, on reset during a fill, abandon the fill: no further fill writes and no oFillDone pulse.

Verification
REQ-035 CPU write col=0x10, row=0x20, color=5, idle fill -> exactly one oWriteEnable cycle, 2 cycles after the strobe, with address 0x1020 and data 5.
REQ-036 Fill col0=0xFE, row0=0x05, 3x2, color=2 -> 6 consecutive writes to FE05, FF05, 0005, FE06, FF06, 0006 with data 2, then one oFillDone pulse; oFillBusy then falls.
REQ-037 Fill with width=0, height=7 -> no writes, oFillDone pulses 2 cycles after start.
REQ-038 CPU strobing every cycle during a 16x1 fill -> output sources alternate CPU, fill, CPU, fill...; fill completes in 32 cycles; oCpuOverflow reaches 1 and stays 1 until reset; no dropped entry is ever written.
REQ-039 Reset=0 asserted mid-fill after 3 pixels -> outputs 0 with no clock edge; after release, no writes, oFillBusy=0, and oFillDone never pulses.
REQ-040 iFillStart re-pulsed during FILL -> ignored; write sequence and count identical to a single start.

Source files
------------

// File: rtl/video_write_scheduler.sv
// Arbitrates single-pixel CPU writes (queued in a small FIFO) against a
// rectangle-fill engine onto one video RAM write port with registered outputs.
module video_write_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iCpuWrite,
  input  logic [7:0]  iCpuCol,
  input  logic [7:0]  iCpuRow,
  input  logic [2:0]  iCpuColor,
  input  logic        iFillStart,
  input  logic [7:0]  iFillCol0,
  input  logic [7:0]  iFillRow0,
  input  logic [7:0]  iFillWidth,
  input  logic [7:0]  iFillHeight,
  input  logic [2:0]  iFillColor,
  output logic        oFillBusy,
  output logic        oFillDone,
  output logic        oCpuOverflow,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [2:0]  oDataOut,
  output logic [1:0]  oFillState
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_e;

  // CPU FIFO: entries are {col, row, color}
  logic [18:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, push_ok, cpu_pop, overflow_q;
  logic [18:0]   fifo_head;

  // Fill engine
  fill_state_e state_q;
  logic [7:0]  col0_q, row0_q, width_q, height_q, x_q, y_q;
  logic [2:0]  color_q;
  logic        done_q;
  logic [7:0]  pix_col, pix_row;

  // Arbiter and output port
  logic        req_cpu, req_fill, contest, grant_cpu, grant_fill;
  logic        last_fill_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [2:0]  data_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  assign req_cpu    = !fifo_empty;
  assign req_fill   = (state_q == S_FILL);
  assign contest    = req_cpu && req_fill;
  // On a contest the CPU wins only if the fill won the previous contest.
  assign grant_cpu  = req_cpu && (!req_fill || last_fill_q);
  assign grant_fill = req_fill && !grant_cpu;

  assign cpu_pop    = grant_cpu;
  assign push_ok    = iCpuWrite && (!fifo_full || cpu_pop);

  assign pix_col    = col0_q + x_q;
  assign pix_row    = row0_q + y_q;

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {iCpuCol, iCpuRow, iCpuColor};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (cpu_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, cpu_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (iCpuWrite && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      col0_q   <= '0;
      row0_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      color_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      // The completion pulse follows the single cycle spent in DONE.
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (iFillStart) begin
            col0_q   <= iFillCol0;
            row0_q   <= iFillRow0;
            width_q  <= iFillWidth;
            height_q <= iFillHeight;
            color_q  <= iFillColor;
            x_q      <= '0;
            y_q      <= '0;
            state_q  <= (iFillWidth == '0 || iFillHeight == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (grant_fill) begin
            if (x_q == width_q - 8'd1) begin
              x_q <= '0;
              if (y_q == height_q - 8'd1) begin
                state_q <= S_DONE;
              end else begin
                y_q <= y_q + 8'd1;
              end
            end else begin
              x_q <= x_q + 8'd1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      last_fill_q <= 1'b1;
    end else begin
      we_q <= grant_cpu || grant_fill;
      if (grant_cpu) begin
        addr_q <= fifo_head[18:3];
        data_q <= fifo_head[2:0];
      end else if (grant_fill) begin
        addr_q <= {pix_col, pix_row};
        data_q <= color_q;
      end
      if (contest) last_fill_q <= grant_fill;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oDataOut      = data_q;
  assign oFillBusy     = (state_q == S_FILL) || (state_q == S_DONE);
  assign oFillDone     = done_q;
  assign oCpuOverflow  = overflow_q;
  assign oFillState    = state_q;

endmodule

// File: tb/tb_video_write_scheduler.sv
// Scoreboard bench for video_write_scheduler: expected pixel writes are queued
// as stimulus is driven and matched against every observed RAM write.
module tb_video_write_scheduler;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iCpuWrite, iFillStart;
  logic [7:0]  iCpuCol, iCpuRow, iFillCol0, iFillRow0, iFillWidth, iFillHeight;
  logic [2:0]  iCpuColor, iFillColor;
  logic        oFillBusy, oFillDone, oCpuOverflow, oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [2:0]  oDataOut;
  logic [1:0]  oFillState;

  video_write_scheduler #(.FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuCol(iCpuCol), .iCpuRow(iCpuRow), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iFillCol0(iFillCol0), .iFillRow0(iFillRow0),
    .iFillWidth(iFillWidth), .iFillHeight(iFillHeight), .iFillColor(iFillColor),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oCpuOverflow(oCpuOverflow),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oDataOut(oDataOut),
    .oFillState(oFillState)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [18:0] cpu_q[$];
  logic [18:0] fill_q[$];
  bit          src_log[$];
  logic [2:0]  fill_color_sb = 3'd0;
  logic [18:0] got_wr;
  logic [18:0] exp_wr;
  int wr_count = 0, fill_wr_count = 0, done_count = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, last_fill_wr_cyc = 0, done_cyc = 0;

  always @(negedge Clock) begin
    if (Reset === 1'b1 && oWriteEnable === 1'b1) begin
      got_wr = {oWriteAddress, oDataOut};
      if (wr_count == 0) first_wr_cyc = cyc;
      wr_count++;
      last_wr_cyc = cyc;
      if (fill_q.size() > 0 && oDataOut == fill_color_sb) begin
        src_log.push_back(1'b1);
        fill_wr_count++;
        last_fill_wr_cyc = cyc;
        exp_wr = fill_q.pop_front();
        check("fill_write", 32'(got_wr), 32'(exp_wr));
      end else begin
        src_log.push_back(1'b0);
        if (cpu_q.size() > 0) begin
          exp_wr = cpu_q.pop_front();
          check("cpu_write", 32'(got_wr), 32'(exp_wr));
        end else begin
          check("unexpected_write_we", 32'(oWriteEnable), 32'd0);
        end
      end
    end
    if (Reset === 1'b1 && oFillDone === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_sb();
    wr_count = 0;
    fill_wr_count = 0;
    done_count = 0;
    src_log.delete();
  endtask

  task automatic drive_fill(input logic [7:0] c0, input logic [7:0] r0, input logic [7:0] w,
                            input logic [7:0] h, input logic [2:0] color, input bit expect_it);
    iFillStart  = 1'b1;
    iFillCol0   = c0;
    iFillRow0   = r0;
    iFillWidth  = w;
    iFillHeight = h;
    iFillColor  = color;
    if (expect_it) begin
      fill_color_sb = color;
      for (int y = 0; y < int'(h); y++)
        for (int x = 0; x < int'(w); x++)
          fill_q.push_back({8'(int'(c0) + x), 8'(int'(r0) + y), color});
    end
  endtask

  task automatic drive_cpu(input logic [7:0] c, input logic [7:0] r, input logic [2:0] color,
                           input bit accepted);
    iCpuWrite = 1'b1;
    iCpuCol   = c;
    iCpuRow   = r;
    iCpuColor = color;
    if (accepted) cpu_q.push_back({c, r, color});
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (done_count == d0) check("done_timeout", 32'(done_count), 32'(d0 + 1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},   32'(oWriteEnable),  32'd0);
    check({tag, "_addr"}, 32'(oWriteAddress), 32'd0);
    check({tag, "_data"}, 32'(oDataOut),      32'd0);
    check({tag, "_busy"}, 32'(oFillBusy),     32'd0);
    check({tag, "_done"}, 32'(oFillDone),     32'd0);
    check({tag, "_ovf"},  32'(oCpuOverflow),  32'd0);
  endtask

  // ---------------- test sequence ----------------
  int s;
  int n_wait;

  initial begin
    Reset = 1'b0;
    iCpuWrite = 1'b0; iCpuCol = '0; iCpuRow = '0; iCpuColor = '0;
    iFillStart = 1'b0; iFillCol0 = '0; iFillRow0 = '0;
    iFillWidth = '0; iFillHeight = '0; iFillColor = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    check("reset_state", 32'(oFillState), 32'd0);
    Reset = 1'b1;
    repeat (2) tick();

    // Single CPU write with the fill idle.
    clear_sb();
    s = cyc;
    drive_cpu(8'h10, 8'h20, 3'd5, 1'b1);
    tick();
    iCpuWrite = 1'b0;
    repeat (6) tick();
    check("cpu_single_count", 32'(wr_count), 32'd1);
    check("cpu_single_latency", 32'(first_wr_cyc - s), 32'd2);
    check("cpu_single_addr", {16'h0, oWriteAddress}, 32'h1020);

    // 3x2 fill wrapping past column 0xFF.
    clear_sb();
    s = cyc;
    drive_fill(8'hFE, 8'h05, 8'd3, 8'd2, 3'd2, 1'b1);
    tick();
    iFillStart = 1'b0;
    wait_done(40);
    check("fill_busy_after_done", 32'(oFillBusy), 32'd0);
    repeat (3) tick();
    check("fill_count", 32'(wr_count), 32'd6);
    check("fill_first_latency", 32'(first_wr_cyc - s), 32'd2);
    check("fill_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd5);
    check("fill_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("fill_done_pulses", 32'(done_count), 32'd1);
    check("fill_q_drained", 32'(fill_q.size()), 32'd0);

    // Zero-width fill: no writes, done two cycles after start.
    clear_sb();
    s = cyc;
    drive_fill(8'h11, 8'h22, 8'd0, 8'd7, 3'd3, 1'b1);
    tick();
    iFillStart = 1'b0;
    wait_done(10);
    repeat (3) tick();
    check("zero_fill_writes", 32'(wr_count), 32'd0);
    check("zero_fill_done_latency", 32'(done_cyc - s), 32'd2);
    check("zero_fill_done_pulses", 32'(done_count), 32'd1);

    // CPU strobing every cycle during a 16x1 fill: strict alternation, CPU
    // first; after the FIFO fills, strobes landing on fill-granted cycles drop.
    clear_sb();
    s = cyc;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) drive_fill(8'h30, 8'h40, 8'd16, 8'd1, 3'd2, 1'b1);
      drive_cpu(8'(k), 8'(8'h80 + k), 3'd5, (k < 8) || (k % 2 == 1));
      tick();
      iFillStart = 1'b0;
    end
    iCpuWrite = 1'b0;
    wait_done(60);
    repeat (10) tick();
    check("mix_total_writes", 32'(wr_count), 32'd36);
    check("mix_fill_writes", 32'(fill_wr_count), 32'd16);
    check("mix_fill_span", 32'(last_fill_wr_cyc - s), 32'd33);
    check("mix_first_write", 32'(first_wr_cyc - s), 32'd2);
    for (int i = 0; i < 32 && i < src_log.size(); i++)
      check($sformatf("mix_src_%0d", i), 32'(src_log[i]), 32'(i % 2));
    check("mix_cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("mix_fill_q_drained", 32'(fill_q.size()), 32'd0);
    check("mix_overflow", 32'(oCpuOverflow), 32'd1);

    // Re-pulsed start during FILL is ignored.
    clear_sb();
    drive_fill(8'h50, 8'h60, 8'd4, 8'd2, 3'd6, 1'b1);
    tick();
    iFillStart = 1'b0;
    tick();
    drive_fill(8'h00, 8'h00, 8'd1, 8'd1, 3'd1, 1'b0);
    tick();
    iFillStart = 1'b0;
    tick();
    drive_fill(8'h01, 8'h01, 8'd2, 8'd2, 3'd1, 1'b0);
    tick();
    iFillStart = 1'b0;
    wait_done(40);
    repeat (5) tick();
    check("restart_count", 32'(wr_count), 32'd8);
    check("restart_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd7);
    check("restart_done_pulses", 32'(done_count), 32'd1);
    check("restart_fill_q_drained", 32'(fill_q.size()), 32'd0);
    check("overflow_sticky", 32'(oCpuOverflow), 32'd1);

    // Reset asserted mid-fill after three pixels.
    clear_sb();
    drive_fill(8'h00, 8'h10, 8'd8, 8'd4, 3'd4, 1'b1);
    tick();
    iFillStart = 1'b0;
    n_wait = 0;
    while (fill_wr_count < 3 && n_wait < 20) begin
      @(negedge Clock);
      #1;
      n_wait++;
    end
    check("midreset_pixels_before", 32'(fill_wr_count), 32'd3);
    check("midreset_busy_before", 32'(oFillBusy), 32'd1);
    #1;
    Reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    fill_q.delete();
    repeat (3) tick();
    Reset = 1'b1;
    clear_sb();
    repeat (20) tick();
    check("postreset_writes", 32'(wr_count), 32'd0);
    check("postreset_done", 32'(done_count), 32'd0);
    check("postreset_busy", 32'(oFillBusy), 32'd0);
    check("postreset_ovf", 32'(oCpuOverflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
